// File: rtl/feu_compteur.sv
// feu_compteur -- countdown display for a four-phase traffic light.
//
// The light pattern from the traffic-light controller is synchronised and
// watched for changes. A change to one of the four known patterns reloads
// the countdown with that phase's duration and reports the phase index.
// A change to any other pattern raises err. The countdown steps down once
// per tick and stops at 1. The value is shown on a two-digit, multiplexed,
// active-low seven-segment display.
//
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   tick    in   one-cycle pulse per second
//   feu_in  in   [5:0] light pattern, asynchronous to clk
//   seg     out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   an      out  [1:0] digit enables, active-low (an[0] units, an[1] tens)
//   phase   out  [1:0] current phase index
//   err     out  high while feu_in holds an unknown pattern
module feu_compteur #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned T_S1     = 15,
    parameter int unsigned T_S2     = 3,
    parameter int unsigned T_S3     = 10,
    parameter int unsigned T_S4     = 3,
    parameter logic [5:0]  LED_S1   = 6'b101011,
    parameter logic [5:0]  LED_S2   = 6'b110011,
    parameter logic [5:0]  LED_S3   = 6'b011101,
    parameter logic [5:0]  LED_S4   = 6'b011110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [5:0] feu_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [1:0] phase,
    output logic       err
);

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    localparam int unsigned SCAN_W   = $clog2(SCAN_DIV);
    localparam logic [3:0]  CNT_RST  = 4'(T_S1);
    localparam logic [3:0]  UNIT_RST = (CNT_RST >= 4'd10) ? CNT_RST - 4'd10 : CNT_RST;
    localparam logic [6:0]  SEG_RST  = seg_code(UNIT_RST);
    localparam logic [6:0]  SEG_TEN  = 7'h79;
    localparam logic [6:0]  SEG_BLK  = 7'h7F;
    localparam logic [6:0]  SEG_DASH = 7'h3F;

    logic [5:0]        sync1_q, sync2_q, prev_q;
    logic [3:0]        count_q, count_d;
    logic [1:0]        phase_q, phase_d;
    logic              err_q, err_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic              dsel_q, dsel_d;
    logic [6:0]        seg_q, seg_d;
    logic [1:0]        an_q, an_d;

    logic              change;
    logic              hit;
    logic [1:0]        hit_phase;
    logic [3:0]        hit_count;
    logic              tens;
    logic [3:0]        units;

    // Input synchroniser and change history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= LED_S1;
            sync2_q <= LED_S1;
            prev_q  <= LED_S1;
        end else begin
            sync1_q <= feu_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign change = (sync2_q != prev_q);

    always_comb begin
        hit       = 1'b1;
        hit_phase = 2'd0;
        hit_count = 4'(T_S1);
        if (sync2_q == LED_S1) begin
            hit_phase = 2'd0;
            hit_count = 4'(T_S1);
        end else if (sync2_q == LED_S2) begin
            hit_phase = 2'd1;
            hit_count = 4'(T_S2);
        end else if (sync2_q == LED_S3) begin
            hit_phase = 2'd2;
            hit_count = 4'(T_S3);
        end else if (sync2_q == LED_S4) begin
            hit_phase = 2'd3;
            hit_count = 4'(T_S4);
        end else begin
            hit = 1'b0;
        end
    end

    // A pattern change always takes priority over a coincident tick
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        err_d   = err_q;
        if (change) begin
            if (hit) begin
                count_d = hit_count;
                phase_d = hit_phase;
                err_d   = 1'b0;
            end else begin
                err_d   = 1'b1;
            end
        end else if (tick && !err_q && (count_q > 4'd1)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CNT_RST;
            phase_q <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
            err_q   <= err_d;
        end
    end

    // Digit scan timing
    always_comb begin
        scan_d = scan_q + 1'b1;
        dsel_d = dsel_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            dsel_d = ~dsel_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
            dsel_q <= 1'b0;
        end else begin
            scan_q <= scan_d;
            dsel_q <= dsel_d;
        end
    end

    // Display decode, registered one cycle behind count/err/dsel
    assign tens  = (count_q >= 4'd10);
    assign units = tens ? count_q - 4'd10 : count_q;

    always_comb begin
        an_d = dsel_q ? 2'b01 : 2'b10;
        if (err_q) begin
            seg_d = SEG_DASH;
        end else if (!dsel_q) begin
            seg_d = seg_code(units);
        end else begin
            seg_d = tens ? SEG_TEN : SEG_BLK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_RST;
            an_q  <= 2'b10;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign phase = phase_q;
    assign err   = err_q;

endmodule

// File: tb/tb_feu_compteur.sv
// tb_feu_compteur -- directed bench for feu_compteur with a behavioural
// reference model and per-cycle output comparison.
module tb_feu_compteur;

    localparam int SD = 4;
    localparam logic [5:0] LED_TAB [4] = '{6'b101011, 6'b110011, 6'b011101, 6'b011110};
    localparam int         T_TAB   [4] = '{15, 3, 10, 3};
    localparam logic [6:0] DIG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic [5:0] feu_in = LED_TAB[0];
    logic [6:0] seg;
    logic [1:0] an;
    logic [1:0] phase;
    logic       err;

    int errors = 0;
    int checks = 0;

    feu_compteur #(.SCAN_DIV(SD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .feu_in (feu_in),
        .seg    (seg),
        .an     (an),
        .phase  (phase),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A pattern seen by the bench at edge n is acted on at edge n+2; it is a
    // change when it differs from the pattern seen at edge n-1.
    logic [5:0] h1, h2, h3;
    int         m_count, m_phase, m_cyc;
    bit         m_err, m_dsel;
    int         dc;
    bit         de, dd;

    function automatic int led_index(input logic [5:0] p);
        for (int i = 0; i < 4; i++)
            if (p == LED_TAB[i]) return i;
        return -1;
    endfunction

    function automatic logic [6:0] exp_seg(input int c, input bit e, input bit d);
        if (e) return 7'h3F;
        if (!d) return DIG_TAB[c % 10];
        return (c >= 10) ? DIG_TAB[1] : 7'h7F;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 <= LED_TAB[0]; h2 <= LED_TAB[0]; h3 <= LED_TAB[0];
            m_count <= T_TAB[0]; m_phase <= 0; m_err <= 1'b0;
            m_cyc <= 0; m_dsel <= 1'b0;
            dc <= T_TAB[0]; de <= 1'b0; dd <= 1'b0;
        end else begin
            h1 <= feu_in; h2 <= h1; h3 <= h2;
            dc <= m_count; de <= m_err; dd <= m_dsel;
            m_cyc  <= m_cyc + 1;
            m_dsel <= (((m_cyc + 1) / SD) % 2) == 1;
            if (h2 != h3) begin
                if (led_index(h2) >= 0) begin
                    m_count <= T_TAB[led_index(h2)];
                    m_phase <= led_index(h2);
                    m_err   <= 1'b0;
                end else begin
                    m_err <= 1'b1;
                end
            end else if (tick && !m_err && m_count > 1) begin
                m_count <= m_count - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("seg", seg, exp_seg(dc, de, dd));
            chk("an", an, dd ? 2'b01 : 2'b10);
            chk("phase", phase, m_phase);
            chk("err", err, m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic wait_an(input logic [1:0] want);
        bit got = 1'b0;
        for (int i = 0; i < 3 * SD && !got; i++) begin
            if (an == want) got = 1'b1;
            else step();
        end
        if (!got) chk("wait_an_timeout", an, want);
    endtask

    task automatic chk_digits(input string name, input logic [6:0] u, input logic [6:0] t);
        wait_an(2'b10);
        chk({name, "_units"}, seg, u);
        wait_an(2'b01);
        chk({name, "_tens"}, seg, t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ph [4];
        int exp_ld [4];
        exp_ph = '{1, 2, 3, 0};
        exp_ld = '{3, 10, 3, 15};

        // reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_seg", seg, 7'h12);
        chk("rst_an", an, 2'b10);
        chk("rst_phase", phase, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // idle display: 15
        repeat (10) step();
        chk("m_count_15", m_count, 15);
        chk_digits("idle", 7'h12, 7'h79);

        // countdown and hold at 1
        repeat (5) pulse_tick();
        step();
        chk("m_count_10", m_count, 10);
        chk_digits("cnt10", 7'h40, 7'h79);
        repeat (9) pulse_tick();
        step();
        chk("m_count_1", m_count, 1);
        chk_digits("cnt1", 7'h79, 7'h7F);
        repeat (3) pulse_tick();
        step();
        chk("m_count_hold1", m_count, 1);
        chk_digits("hold1", 7'h79, 7'h7F);

        // load of phase 1 with a coincident tick
        feu_in = LED_TAB[1];
        step();                      // edge k
        step();                      // edge k+1
        chk("s2_phase_k1", phase, 0);
        tick = 1'b1;
        step();                      // edge k+2: load wins
        tick = 1'b0;
        chk("s2_phase_k2", phase, 1);
        chk("m_count_3", m_count, 3);
        step();
        step();
        chk_digits("s2", 7'h30, 7'h7F);

        // unknown pattern
        feu_in = 6'b111111;
        step();
        step();
        chk("err_k1", err, 0);
        step();
        chk("err_k2", err, 1);
        repeat (3) pulse_tick();
        chk_digits("dash", 7'h3F, 7'h3F);
        chk("m_count_err_hold", m_count, 3);
        feu_in = LED_TAB[2];
        repeat (3) step();
        chk("s3_err", err, 0);
        chk("s3_phase", phase, 2);
        chk("m_count_s3", m_count, 10);
        step();
        chk_digits("s3", 7'h40, 7'h79);

        // asynchronous reset mid-count with the tens digit selected
        repeat (3) pulse_tick();
        chk("m_count_7", m_count, 7);
        for (int i = 0; i < 3 * SD && !m_dsel; i++) step();
        chk("dsel_before_reset", m_dsel, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", seg, 7'h12);
        chk("arst_an", an, 2'b10);
        chk("arst_phase", phase, 0);
        chk("arst_err", err, 0);
        feu_in = LED_TAB[0];
        @(negedge clk);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("post_rst_phase", phase, 0);
        chk("post_rst_count", m_count, 15);

        // full cycle, controller-style: count down, then switch pattern
        for (int p = 0; p < 4; p++) begin
            repeat (T_TAB[p] - 1) pulse_tick();
            feu_in = LED_TAB[(p + 1) % 4];
            repeat (3) step();
            chk("cycle_phase", phase, exp_ph[p]);
            chk("cycle_load", m_count, exp_ld[p]);
        end

        repeat (3 * SD) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/feu_compteur.md
FEU_COMPTEUR -- requirements
Module: feu_compteur

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per display digit slot (minimum 2).
REQ-002 SHALL have parameters T_S1/T_S2/T_S3/T_S4, defaults 15/3/10/3, meaning phase durations in seconds (1..15).
REQ-003 SHALL have parameters LED_S1/LED_S2/LED_S3/LED_S4, defaults 6'b101011/6'b110011/6'b011101/6'b011110, meaning light patterns of phases 0..3.
REQ-004 SHALL have port clk, input, 1 bit: system clock; the only clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port tick, input, 1 bit: one-clk-cycle pulse per second, synchronous to clk.
REQ-007 SHALL have port feu_in, input, 6 bits: light pattern from the traffic-light controller, quasi-static, asynchronous to clk.
REQ-008 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port an, output, 2 bits: digit enables, active-low; an[0] = units, an[1] = tens.
REQ-010 SHALL have port phase, output, 2 bits: index of the current phase (0..3).
REQ-011 SHALL have port err, output, 1 bit: high while feu_in holds an unknown pattern.

Function
REQ-012 SHALL pass feu_in through a 2-flop synchroniser (sync1, sync2), then through a history register prev <= sync2.
REQ-013 SHALL detect a change whenever sync2 != prev.
REQ-014 On a change to LED_Sn: count <= T_Sn, phase <= n-1, err <= 0, all on the next edge; any tick in the same cycle SHALL be ignored (load wins).
REQ-015 On a change to any other pattern: err <= 1; count and phase hold.
REQ-016 On tick with no change and err=0: count <= count-1 if count>1; count holds at 1 (no wrap to 0 or 15).
REQ-017 While err=1, tick SHALL have no effect.
REQ-018 count SHALL be 4 bits; tens = (count>=10); units = tens ? count-10 : count.
REQ-019 A scan counter SHALL run 0..SCAN_DIV-1 and wrap; on wrap, digit select dsel SHALL toggle.
REQ-020 dsel=0 SHALL drive an=2'b10 with seg = units; dsel=1 SHALL drive an=2'b01 with seg = tens digit, or 7'h7F (blank) when tens=0.
REQ-021 While err=1, both digits SHALL show dash: seg = 7'h3F.
REQ-022 Digit codes (active-low, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-023 seg and an SHALL be registered, updating one clk after count, err or dsel changes.
REQ-024 Latency: a feu_in change settled before edge k SHALL load count at edge k+2 and appear on seg at edge k+3.
REQ-025 A second pattern change arriving while the first is in the synchroniser SHALL be handled in order; each change causes exactly one load or err event.

Reset
REQ-026 rst_n low SHALL immediately force: sync1 = sync2 = prev = LED_S1, count = T_S1 (15), phase = 0, err = 0, scan counter = 0, dsel = 0, an = 2'b10, seg = 7'h12 (units "5").
REQ-027 Reset deasserted mid-phase SHALL restart from the REQ-026 state; feu_in = LED_S1 after reset SHALL cause no change event.
REQ-028 Reset SHALL be released synchronously to clk by the surrounding logic; the block adds no reset synchroniser.

Verification
REQ-029 Scenario: reset, feu_in=LED_S1, SCAN_DIV=4 -> an alternates 10/01 every 4 clk; seg = 12 (units) / 79 (tens); count=15.
REQ-030 Scenario: 5 ticks after reset -> count=10, tens seg=79, units seg=40; 9 further ticks -> count=1; 3 more ticks -> count stays 1.
REQ-031 Scenario: feu_in -> LED_S2 at edge k -> count=3 and phase=1 at k+2; tens digit blank (7F); coincident tick at the load cycle -> count still 3.
REQ-032 Scenario: feu_in=6'b111111 -> err=1 at k+2, seg=3F on both digits, ticks ignored; then feu_in=LED_S3 -> err=0, count=10, phase=2.
REQ-033 Scenario: rst_n pulsed low mid-count (count=7, dsel=1) -> outputs return asynchronously to the REQ-026 values within the same cycle.
REQ-034 Scenario: full cycle S1->S2->S3->S4->S1, with ticks driven as the traffic-light controller's outputs -> phase sequence 0,1,2,3,0; each load value 15,3,10,3,15.
